// File: rtl/mult_chk_pkg.sv
// Shared types and sizing for the multiplier sweep checker.
//   state_t      : sweep controller states
//   N_DEFAULT    : default operand width
//   PW/NPAIRS/SUMW/CNTW : product width, pair count, error-sum width and
//                  error-count width for the default operand width
//   pw/npairs/sumw/cntw : the same sizes for any operand width n
package mult_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int N_DEFAULT = 4;
    localparam int PW        = 2 * N_DEFAULT;
    localparam int NPAIRS    = 1 << PW;
    localparam int SUMW      = 4 * N_DEFAULT;
    localparam int CNTW      = PW + 1;

    function automatic int pw(input int n);
        return 2 * n;
    endfunction

    function automatic int npairs(input int n);
        return 1 << (2 * n);
    endfunction

    function automatic int sumw(input int n);
        return 4 * n;
    endfunction

    function automatic int cntw(input int n);
        return 2 * n + 1;
    endfunction

endpackage

// File: rtl/mult_err_accum.sv
// Error accumulator for the multiplier sweep checker.
// Compares one product per valid cycle against the exact a*b and keeps
// running statistics.
//   clk, rst        : clock, asynchronous active-high reset
//   clr_i           : clear all statistics (wins over a same-cycle compare)
//   cmp_valid_i     : a_i/b_i/prod_i form a pair to compare this edge
//   a_i, b_i        : operands the product belongs to
//   prod_i          : product returned by the multiplier under test
//   err_count_o     : number of mismatching pairs
//   err_sum_o       : sum of absolute errors
//   err_max_o       : largest absolute error
//   fail_seen_o     : at least one mismatch recorded
//   fail_a_o/_b_o   : operands of the first mismatch
module mult_err_accum
    import mult_chk_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  cmp_valid_i,
    input  logic [N-1:0]          a_i,
    input  logic [N-1:0]          b_i,
    input  logic [pw(N)-1:0]      prod_i,
    output logic [cntw(N)-1:0]    err_count_o,
    output logic [sumw(N)-1:0]    err_sum_o,
    output logic [pw(N)-1:0]      err_max_o,
    output logic                  fail_seen_o,
    output logic [N-1:0]          fail_a_o,
    output logic [N-1:0]          fail_b_o
);

    localparam int LPW   = pw(N);
    localparam int LSUMW = sumw(N);
    localparam int LCNTW = cntw(N);

    logic [LPW-1:0]   exp_w;
    logic [LPW-1:0]   diff_w;

    logic [LCNTW-1:0] cnt_q,  cnt_d;
    logic [LSUMW-1:0] sum_q,  sum_d;
    logic [LPW-1:0]   max_q,  max_d;
    logic             seen_q, seen_d;
    logic [N-1:0]     fa_q,   fa_d;
    logic [N-1:0]     fb_q,   fb_d;

    // Zero-extended operands keep the full 2N-bit product.
    assign exp_w  = {{N{1'b0}}, a_i} * {{N{1'b0}}, b_i};
    // Ordered subtraction so the magnitude never wraps.
    assign diff_w = (prod_i >= exp_w) ? (prod_i - exp_w) : (exp_w - prod_i);

    always_comb begin
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        max_d  = max_q;
        seen_d = seen_q;
        fa_d   = fa_q;
        fb_d   = fb_q;
        if (clr_i) begin
            cnt_d  = '0;
            sum_d  = '0;
            max_d  = '0;
            seen_d = 1'b0;
            fa_d   = '0;
            fb_d   = '0;
        end else if (cmp_valid_i && (diff_w != '0)) begin
            cnt_d = cnt_q + 1'b1;
            sum_d = sum_q + LSUMW'(diff_w);
            if (diff_w > max_q) begin
                max_d = diff_w;
            end
            if (!seen_q) begin
                seen_d = 1'b1;
                fa_d   = a_i;
                fb_d   = b_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sum_q  <= '0;
            max_q  <= '0;
            seen_q <= 1'b0;
            fa_q   <= '0;
            fb_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            sum_q  <= sum_d;
            max_q  <= max_d;
            seen_q <= seen_d;
            fa_q   <= fa_d;
            fb_q   <= fb_d;
        end
    end

    assign err_count_o = cnt_q;
    assign err_sum_o   = sum_q;
    assign err_max_o   = max_q;
    assign fail_seen_o = seen_q;
    assign fail_a_o    = fa_q;
    assign fail_b_o    = fb_q;

endmodule

// File: rtl/mult_sweep_checker.sv
// Exhaustive sweep harness for an N-bit multiplier.
// Drives every (A,B) pair once, lines each returned product up with the
// operands that produced it, and accumulates error statistics.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : begin a sweep (honoured only in IDLE or DONE)
//   op_a, op_b          : operands to the multiplier under test
//   op_valid            : op_a/op_b carry a sweep pair
//   prod_in             : product from the multiplier under test
//   busy                : sweep or drain in progress
//   done                : sweep finished, statistics final
//   exact               : done with no mismatches
//   err_count/err_sum/err_max/fail_seen/fail_a/fail_b : error statistics
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// SWEEP | presenting pair idx each cycle
// DRAIN | waiting DUT_LATENCY cycles for the last products
// DONE  | statistics final and held until the next start
module mult_sweep_checker
    import mult_chk_pkg::*;
#(
    parameter int N           = N_DEFAULT,
    parameter int DUT_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [N-1:0]          op_a,
    output logic [N-1:0]          op_b,
    output logic                  op_valid,
    input  logic [pw(N)-1:0]      prod_in,
    output logic                  busy,
    output logic                  done,
    output logic                  exact,
    output logic [cntw(N)-1:0]    err_count,
    output logic [sumw(N)-1:0]    err_sum,
    output logic [pw(N)-1:0]      err_max,
    output logic                  fail_seen,
    output logic [N-1:0]          fail_a,
    output logic [N-1:0]          fail_b
);

    localparam int LPW = pw(N);
    localparam int DCW = (DUT_LATENCY > 1) ? $clog2(DUT_LATENCY) : 1;

    state_t          state_q, state_d;
    logic [LPW-1:0]  idx_q,   idx_d;
    logic [DCW-1:0]  drain_q, drain_d;

    logic            start_acc;
    logic            cmp_valid;
    logic [N-1:0]    cmp_a;
    logic [N-1:0]    cmp_b;

    assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                idx_d = idx_q + 1'b1;
                if (&idx_q) begin
                    state_d = (DUT_LATENCY == 0) ? ST_DONE : ST_DRAIN;
                    // Down-counter terminates at zero, so load latency-1.
                    drain_d = DCW'(DUT_LATENCY - 1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        op_valid = (state_q == ST_SWEEP);
        op_a     = op_valid ? idx_q[N-1:0]   : '0;
        op_b     = op_valid ? idx_q[LPW-1:N] : '0;
        busy     = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
        done     = (state_q == ST_DONE);
    end

    // Operand/valid delay line matching the multiplier's register depth,
    // so each product is compared against the pair that produced it.
    generate
        if (DUT_LATENCY == 0) begin : g_nodelay
            assign cmp_valid = op_valid;
            assign cmp_a     = op_a;
            assign cmp_b     = op_b;
        end else begin : g_delay
            logic [DUT_LATENCY-1:0] vld_q;
            logic [N-1:0]           a_q [DUT_LATENCY];
            logic [N-1:0]           b_q [DUT_LATENCY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int k = 0; k < DUT_LATENCY; k++) begin
                        a_q[k] <= '0;
                        b_q[k] <= '0;
                    end
                end else begin
                    vld_q[0] <= op_valid;
                    a_q[0]   <= op_a;
                    b_q[0]   <= op_b;
                    for (int k = 1; k < DUT_LATENCY; k++) begin
                        vld_q[k] <= vld_q[k-1];
                        a_q[k]   <= a_q[k-1];
                        b_q[k]   <= b_q[k-1];
                    end
                end
            end

            assign cmp_valid = vld_q[DUT_LATENCY-1];
            assign cmp_a     = a_q[DUT_LATENCY-1];
            assign cmp_b     = b_q[DUT_LATENCY-1];
        end
    endgenerate

    mult_err_accum #(.N(N)) u_accum (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (start_acc),
        .cmp_valid_i (cmp_valid),
        .a_i         (cmp_a),
        .b_i         (cmp_b),
        .prod_i      (prod_in),
        .err_count_o (err_count),
        .err_sum_o   (err_sum),
        .err_max_o   (err_max),
        .fail_seen_o (fail_seen),
        .fail_a_o    (fail_a),
        .fail_b_o    (fail_b)
    );

    assign exact = done && (err_count == '0);

endmodule

// File: tb/tb_mult_sweep_checker.sv
module tb_mult_sweep_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance 0: combinational checker, multiplier model selected by mode
    //   0 exact, 1 product stuck at 0, 2 product bit 0 forced low,
    //   3 exact product through two registers (misaligned for latency 0)
    int mode = 0;

    logic       start0 = 1'b0;
    logic [3:0] op_a0, op_b0;
    logic       op_valid0, busy0, done0, exact0, fail_seen0;
    logic [7:0] prod0, err_max0, p0_s1, p0_s2, mul0;
    logic [8:0] err_count0;
    logic [15:0] err_sum0;
    logic [3:0] fail_a0, fail_b0;

    assign mul0 = {4'b0, op_a0} * {4'b0, op_b0};
    always @(posedge clk) begin
        p0_s1 <= mul0;
        p0_s2 <= p0_s1;
    end
    always_comb begin
        case (mode)
            1:       prod0 = 8'd0;
            2:       prod0 = mul0 & 8'hFE;
            3:       prod0 = p0_s2;
            default: prod0 = mul0;
        endcase
    end

    mult_sweep_checker #(.N(4), .DUT_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .op_a(op_a0), .op_b(op_b0), .op_valid(op_valid0), .prod_in(prod0),
        .busy(busy0), .done(done0), .exact(exact0),
        .err_count(err_count0), .err_sum(err_sum0), .err_max(err_max0),
        .fail_seen(fail_seen0), .fail_a(fail_a0), .fail_b(fail_b0)
    );

    // Instance 1: two-stage pipelined exact multiplier, latency-2 checker
    logic       start1 = 1'b0;
    logic [3:0] op_a1, op_b1;
    logic       op_valid1, busy1, done1, exact1, fail_seen1;
    logic [7:0] prod1, err_max1, p1_s1;
    logic [8:0] err_count1;
    logic [15:0] err_sum1;
    logic [3:0] fail_a1, fail_b1;

    always @(posedge clk) begin
        p1_s1 <= {4'b0, op_a1} * {4'b0, op_b1};
        prod1 <= p1_s1;
    end

    mult_sweep_checker #(.N(4), .DUT_LATENCY(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .op_a(op_a1), .op_b(op_b1), .op_valid(op_valid1), .prod_in(prod1),
        .busy(busy1), .done(done1), .exact(exact1),
        .err_count(err_count1), .err_sum(err_sum1), .err_max(err_max1),
        .fail_seen(fail_seen1), .fail_a(fail_a1), .fail_b(fail_b1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts a sweep on the chosen instance (edge e0) and returns the
    // number of edges after e0 until done is seen, or -1 on timeout.
    // pulse_at > 0 re-asserts start0 for one cycle after that edge.
    task automatic run_sweep(input bit inst, input int pulse_at, output int edges);
        @(negedge clk);
        if (inst) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        check("e0_busy",  inst ? busy1 : busy0, 1);
        check("e0_done",  inst ? done1 : done0, 0);
        check("e0_clear", inst ? {err_count1, err_sum1, err_max1, fail_seen1}
                               : {err_count0, err_sum0, err_max0, fail_seen0}, 0);
        edges = -1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            start0 = (k == pulse_at);
            if (inst ? done1 : done0) begin
                edges = k;
                break;
            end
        end
        start0 = 1'b0;
    endtask

    int e;

    initial begin
        // Reset state
        #12;
        check("reset_outputs0", {op_a0, op_b0, op_valid0, busy0, done0, exact0,
                                 err_count0, err_sum0, err_max0, fail_seen0, fail_a0, fail_b0}, 0);
        check("reset_outputs1", {op_a1, op_b1, op_valid1, busy1, done1, exact1,
                                 err_count1, err_sum1, err_max1, fail_seen1}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Exact combinational multiplier
        mode = 0;
        run_sweep(0, -1, e);
        check("exact_done_cycle", e, 256);
        check("exact_stats", {err_count0, err_sum0, err_max0, fail_seen0}, 0);
        check("exact_flag", exact0, 1);
        check("exact_busy_low", busy0, 0);

        // Product stuck at zero
        mode = 1;
        run_sweep(0, -1, e);
        check("stuck_done_cycle", e, 256);
        check("stuck_count", err_count0, 225);
        check("stuck_sum",   err_sum0, 14400);
        check("stuck_max",   err_max0, 225);
        check("stuck_fail_ab", {fail_seen0, fail_a0, fail_b0}, {1'b1, 4'd1, 4'd1});
        check("stuck_exact", exact0, 0);

        // Stats held in DONE
        repeat (5) @(posedge clk);
        #1;
        check("stuck_hold_count", err_count0, 225);
        check("stuck_hold_done",  done0, 1);

        // Restart from DONE: cleared at e0 (inside run_sweep), repeats identically
        run_sweep(0, -1, e);
        check("restart_done_cycle", e, 256);
        check("restart_count", err_count0, 225);
        check("restart_sum",   err_sum0, 14400);

        // Bit 0 forced low
        mode = 2;
        run_sweep(0, -1, e);
        check("p0_done_cycle", e, 256);
        check("p0_count", err_count0, 64);
        check("p0_sum",   err_sum0, 64);
        check("p0_max",   err_max0, 1);
        check("p0_fail_ab", {fail_a0, fail_b0}, {4'd1, 4'd1});

        // Pipelined multiplier with matching latency
        run_sweep(1, -1, e);
        check("pipe_done_cycle", e, 258);
        check("pipe_exact", exact1, 1);
        check("pipe_count", err_count1, 0);

        // Pipelined multiplier against a latency-0 checker: misaligned
        mode = 3;
        run_sweep(0, -1, e);
        check("misalign_done_cycle", e, 256);
        check("misalign_nonzero", (err_count0 != 0), 1);
        check("misalign_exact", exact0, 0);

        // start re-pulsed mid-sweep is ignored
        mode = 0;
        run_sweep(0, 50, e);
        check("repulse_done_cycle", e, 256);
        check("repulse_exact", exact0, 1);

        // Asynchronous reset mid-sweep at idx=100
        mode = 1;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("mid_pair_ab", {op_a0, op_b0}, {4'd4, 4'd6});
        check("mid_errors_present", (err_count0 != 0), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {op_a0, op_b0, op_valid0, busy0, done0, exact0,
                                      err_count0, err_sum0, err_max0, fail_seen0, fail_a0, fail_b0}, 0);
        @(negedge clk);
        rst = 1'b0;
        mode = 0;
        run_sweep(0, -1, e);
        check("post_reset_done_cycle", e, 256);
        check("post_reset_exact", exact0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_sweep_checker.md
Name: mult_sweep_checker

Overview:
- Sequential harness that exhaustively sweeps every operand pair into a combinational or pipelined N-bit multiplier (default the 4-bit composed multiplier) and reads back each product.
- Compares each product against the exact A*B and accumulates error statistics: mismatch count, absolute-error sum, maximum absolute error, first failing pair.
- Sits directly upstream and downstream of the multiplier under test: drives its A/B inputs and consumes its P output. Results feed the scoring/reward flow for learned multiplier candidates.

Parameters:
- N, 4, operand width; product width is 2N.
- DUT_LATENCY, 0, register stages inside the multiplier under test (0 = combinational).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin sweep; sampled only in IDLE or DONE
- op_a  out  N  operand A to multiplier
- op_b  out  N  operand B to multiplier
- op_valid  out  1  high while op_a/op_b carry a sweep pair
- prod_in  in  2N  product P returned by multiplier
- busy  out  1  high in SWEEP and DRAIN
- done  out  1  level, high in DONE until next accepted start or reset
- exact  out  1  done && err_count==0
- err_count  out  2N+1  number of mismatching pairs
- err_sum  out  4N  sum of |prod_in - A*B|
- err_max  out  2N  max |prod_in - A*B|
- fail_seen  out  1  at least one mismatch recorded
- fail_a  out  N  op_a of first (lowest-index) mismatch
- fail_b  out  N  op_b of first mismatch

Behaviour:
- Clock is clk only; reset is asynchronous and active-high on rst. Reset forces state IDLE and all outputs to 0. Reset mid-sweep aborts; no partial stats survive.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE/DONE + start: at edge e0, state←SWEEP, idx←0, all stats and fail capture cleared, done←0.
- SWEEP: idx (2N bits) increments each edge; op_a=idx[N-1:0], op_b=idx[2N-1:N]; op_valid=1. Pair i is presented in the cycle after edge e(i).
- Leaving SWEEP at the edge where idx is all-ones: →DONE if DUT_LATENCY=0, else →DRAIN.
- DRAIN: op_valid=0, op_a/op_b=0; lasts DUT_LATENCY cycles, then →DONE.
- Outside SWEEP: op_a=op_b=0, op_valid=0.
- Alignment: valid and operand copy pass through a DUT_LATENCY-deep delay line. prod_in for pair i is sampled at edge e(i+DUT_LATENCY+1) and compared to the delayed a*b, computed exactly in 2N bits.
- Stat update per compared pair:
  - diff = |prod_in - exp|, computed unsigned without wrap.
  - If diff≠0: err_count+1, err_sum+diff, err_max=max(err_max,diff).
  - If additionally fail_seen=0: capture fail_a/fail_b and set fail_seen.
- Completion: the final accumulation and the transition to DONE happen on the same edge, e(2^(2N)+DUT_LATENCY). Stats are final when done rises.
- Stats hold stable in DONE; start in DONE restarts the sweep from e0 semantics.
- start while busy is ignored; the sweep is not restarted.
- Counter widths are guaranteed not to overflow: worst-case err_sum = 2^(2N)·(2^(2N)-1) < 2^(4N).

Decomposition:
- Shared package mult_chk_pkg:
  - state enum (IDLE, SWEEP, DRAIN, DONE)
  - localparams PW=2N, NPAIRS=2^(2N), SUMW=4N, CNTW=2N+1
- One sub-module mult_err_accum: takes compare valid, delayed a/b, prod_in and clear; holds the diff/count/sum/max/first-fail registers. The top level keeps the FSM, idx counter and alignment delay line.

Test Plan:
- Exact combinational multiplier, DUT_LATENCY=0, pulse start → done rises at e256; err_count=0, err_sum=0, err_max=0, exact=1, fail_seen=0.
- Model with P stuck at 0 → err_count=225, err_sum=14400, err_max=225, fail_a=1, fail_b=1, exact=0.
- Exact multiplier with P[0] forced 0 → err_count=64, err_sum=64, err_max=1, fail_a=1, fail_b=1.
- Exact multiplier with 2 register stages, DUT_LATENCY=2 → done at e258, exact=1. Same DUT with DUT_LATENCY=0 → err_count>0 (misalignment detected).
- rst asserted asynchronously mid-sweep (idx=100) → all outputs 0 immediately, state IDLE. A following start with the exact DUT → exact=1 at e256.
- start re-pulsed at e50 during SWEEP → ignored; done still at e256 with correct stats. start in DONE → stats clear at e0 and the sweep repeats identically.
